mac_dot_seq: RTL
================

MAC_DOT_SEQ -- requirements
Module: mac_dot_seq

Interface
REQ-001 Parameter LEN_W, default 8, width of the vector-length field and beat counter.
REQ-002 Port clk  input  1  clock; all state changes on the rising edge.
REQ-003 Port rst  input  1  reset, asynchronous, active-high.
REQ-004 Port start  input  1  begin a dot-product job; sampled only in IDLE.
REQ-005 Port len  input  LEN_W  number of (a,b) beats in the job; latched with start.
REQ-006 Port abort  input  1  cancel the job in RUN without producing a result.
REQ-007 Port in_valid  input  1  operand beat valid.
REQ-008 Port in_ready  output  1  sequencer accepts a beat.
REQ-009 Port a  input  8  unsigned operand A.
REQ-010 Port b  input  8  unsigned operand B.
REQ-011 Port out_valid  output  1  result valid.
REQ-012 Port out_ready  input  1  consumer accepts the result.
REQ-013 Port result  output  16  accumulated dot product.
REQ-014 Port ovf  output  1  sticky per-job flag: the accumulation exceeded 16'hFFFF.
REQ-015 Port busy  output  1  high in RUN or HOLD.

Function
REQ-016 FSM states are IDLE, RUN and HOLD.
REQ-017 IDLE: in_ready=0, out_valid=0, busy=0.
REQ-018 IDLE with start=1 and len!=0: latch len into the remaining counter, clear the accumulator and ovf, go to RUN.
REQ-019 IDLE with start=1 and len==0: clear the accumulator and ovf, go to HOLD with result=0.
REQ-020 RUN: in_ready=1; a beat transfers only when in_valid and in_ready are both high.
REQ-021 Each transfer: acc <= acc + a*b, where a*b is the unsigned 16-bit product and the sum is 17-bit before width handling; remaining decrements by 1.
REQ-022 A transfer with carry-out of bit 15 sets ovf; ovf stays set until the next start.
REQ-023 Cycles with in_valid=0 in RUN change no state.
REQ-024 Transfer of the last beat (remaining==1): go to HOLD; result holds the final sum and out_valid=1 on the next cycle.
REQ-025 Latency: one clock from the last accepted beat to out_valid.
REQ-026 HOLD: out_valid=1, in_ready=0; result and ovf stay stable until handshake.
REQ-027 HOLD with out_ready=1: return to IDLE next cycle; out_valid=0 from then.
REQ-028 start is ignored in RUN and HOLD; start asserted during the HOLD handshake cycle is not captured.
REQ-029 abort=1 in RUN: return to IDLE next cycle, no out_valid pulse; any beat offered in that cycle is discarded.
REQ-030 abort is ignored in IDLE and HOLD.
REQ-031 result is driven from the accumulator register in every state.

Reset
REQ-032 rst=1 immediately forces IDLE, acc=0, remaining=0, ovf=0, result=0, in_ready=0, out_valid=0, busy=0.
REQ-033 rst asserted in RUN or HOLD abandons the job; no result is emitted after release.

Configuration
REQ-034 Macro MAC_DOT_SAT_EN selects how the accumulator handles overflow.
REQ-035 When MAC_DOT_SAT_EN is defined, an overflowing accumulation clamps acc to 16'hFFFF and later beats keep it there.
REQ-036 When MAC_DOT_SAT_EN is undefined, acc wraps modulo 2^16.
REQ-037 ovf behaves identically in both builds.

Verification
REQ-038 len=3; beats (2,3),(4,5),(10,10) -> out_valid one cycle after beat 3, result=16'h007E, ovf=0.
REQ-039 len=0 start -> out_valid=1 on the next cycle, result=0, in_ready never asserted.
REQ-040 len=2; beats (255,255) twice -> ovf=1; result=16'hFC02 without MAC_DOT_SAT_EN, 16'hFFFF with it.
REQ-041 len=4 with in_valid low on alternate cycles, beats (1,1) each -> result=4, exactly 4 transfers counted.
REQ-042 HOLD with out_ready low 5 cycles and start pulsed -> result stable, start ignored; out_ready=1 -> IDLE next cycle.
REQ-043 abort after 2 of 4 beats -> IDLE, no out_valid; rst mid-RUN -> all outputs 0 while rst is high.

Source files
------------

// File: rtl/mac_dot_seq.sv
// mac_dot_seq: sequential unsigned 8x8 dot-product engine.
//
// A job starts in IDLE when start is high; len (a,b) beats are accumulated in
// RUN, and the 16-bit sum is presented in HOLD until the consumer takes it.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start, len           begin a job of len beats (sampled only in IDLE)
//   abort                cancel the job in RUN, no result produced
//   in_valid, in_ready   operand beat handshake
//   a, b                 unsigned 8-bit operands
//   out_valid, out_ready result handshake
//   result               accumulator value (driven in every state)
//   ovf                  sticky per-job overflow flag
//   busy                 high in RUN or HOLD
//
// Build option: define MAC_DOT_SAT_EN to clamp the accumulator at 16'hFFFF on
// overflow; otherwise it wraps modulo 2^16. ovf behaves the same either way.

module mac_dot_seq #(
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      result,
    output logic             ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHold
    } state_e;

    state_e           state_q, state_d;
    logic [15:0]      acc_q, acc_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             ovf_q, ovf_d;

    logic [15:0] prod;
    logic [16:0] sum;

    assign prod = {8'd0, a} * {8'd0, b};
    assign sum  = {1'b0, acc_q} + {1'b0, prod};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    acc_d = 16'd0;
                    ovf_d = 1'b0;
                    if (len != '0) begin
                        rem_d   = len;
                        state_d = StRun;
                    end else begin
                        state_d = StHold;
                    end
                end
            end
            StRun: begin
                // Abort wins over a beat offered in the same cycle.
                if (abort) begin
                    state_d = StIdle;
                end else if (in_valid) begin
                    ovf_d = ovf_q | sum[16];
`ifdef MAC_DOT_SAT_EN
                    acc_d = sum[16] ? 16'hFFFF : sum[15:0];
`else
                    acc_d = sum[15:0];
`endif
                    rem_d = rem_q - 1'b1;
                    if (rem_q == LEN_W'(1)) begin
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= 16'd0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == StRun);
        out_valid = (state_q == StHold);
        busy      = (state_q != StIdle);
        result    = acc_q;
        ovf       = ovf_q;
    end

endmodule
